// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package booth_pkg;

    localparam int WIDTH = 64;
    localparam int ACC_W = 66;
    localparam int ITERS = 32;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        NEG,
        CALC,
        DONE
    } state_t;

    // Partial-product select codes produced by the digit decoder.
    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_POS1,
        SEL_POS2,
        SEL_NEG1,
        SEL_NEG2
    } sel_t;

    // Radix-4 Booth digits: {b[2i+1], b[2i], b[2i-1]}.
    localparam logic [2:0] DIG_ZERO_L = 3'b000;
    localparam logic [2:0] DIG_POS1_L = 3'b001;
    localparam logic [2:0] DIG_POS1_H = 3'b010;
    localparam logic [2:0] DIG_POS2   = 3'b011;
    localparam logic [2:0] DIG_NEG2   = 3'b100;
    localparam logic [2:0] DIG_NEG1_L = 3'b101;
    localparam logic [2:0] DIG_NEG1_H = 3'b110;
    localparam logic [2:0] DIG_ZERO_H = 3'b111;

    function automatic sel_t booth_decode(input logic [2:0] dig);
        sel_t sel;
        sel = SEL_ZERO;
        case (dig)
            DIG_POS1_L, DIG_POS1_H: sel = SEL_POS1;
            DIG_POS2:               sel = SEL_POS2;
            DIG_NEG2:               sel = SEL_NEG2;
            DIG_NEG1_L, DIG_NEG1_H: sel = SEL_NEG1;
            default:                sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

    function automatic logic [ACC_W-1:0] sext_acc(input logic [WIDTH-1:0] v);
        return {{(ACC_W - WIDTH){v[WIDTH-1]}}, v};
    endfunction

endpackage

// File: rtl/adder_66.sv
// Plain 66-bit binary adder shared by the multiplier datapath.
// Latency: combinational.
// Backpressure: none.
module adder_66 (
    input  logic [65:0] a,
    input  logic [65:0] b,
    output logic [65:0] sum,
    output logic        cout
);

    // Full-width add with carry-out exposed.
    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/booth_pp_sel.sv
// Maps a radix-4 Booth digit to its 66-bit partial product (0, +-A, +-2A).
// Latency: combinational.
// Backpressure: none.
module booth_pp_sel
    import booth_pkg::*;
(
    input  logic [2:0]       dig,
    input  logic [ACC_W-1:0] a_ext,
    input  logic [ACC_W-1:0] nega,
    output logic [ACC_W-1:0] pp
);

    // Select the partial product; doubling is a 1-bit left shift within ACC_W.
    always_comb begin
        pp = '0;
        case (booth_decode(dig))
            SEL_POS1: pp = a_ext;
            SEL_POS2: pp = {a_ext[ACC_W-2:0], 1'b0};
            SEL_NEG1: pp = nega;
            SEL_NEG2: pp = {nega[ACC_W-2:0], 1'b0};
            default:  pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed 64x64->128 radix-4 Booth multiplier built around one shared adder_66.
// Latency: out_valid 34 cycles after accept; one product per 35 cycles at best.
// Backpressure: p held in DONE until out_ready; in_ready only in IDLE.
module booth_mul_seq #(
    parameter int WIDTH = 64  // datapath is fixed to 64 by the 66-bit adder
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    import booth_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH:0]     mul_q;    // {b, 1'b0}; product low bits shift in from the top
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   nega_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] p_q;

    logic [ACC_W-1:0]       a_ext;
    logic [ACC_W-1:0]       pp;
    logic [ACC_W-1:0]       add_a;
    logic [ACC_W-1:0]       add_b;
    logic [ACC_W-1:0]       add_sum;
    logic                   unused_cout;
    logic [ACC_W+WIDTH:0]   shift_d;

    assign a_ext = sext_acc(a_q);
    assign p     = p_q;

    booth_pp_sel u_pp_sel (
        .dig   (mul_q[2:0]),
        .a_ext (a_ext),
        .nega  (nega_q),
        .pp    (pp)
    );

    // The only adder: forms -A in NEG, acc + pp in CALC.
    adder_66 u_add (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .cout (unused_cout)
    );

    // Adder operand steering and the 2-bit arithmetic shift of {sum, multiplier}.
    always_comb begin
        add_a = acc_q;
        add_b = pp;
        if (state_q == NEG) begin
            add_a = ~a_ext;
            add_b = ACC_W'(1);
        end
        shift_d = $signed({add_sum, mul_q}) >>> 2;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = NEG;
            end
            NEG:  state_d = CALC;
            CALC: if (cnt_q == LAST_ITER) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, -A precompute, Booth iterations and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            mul_q  <= '0;
            acc_q  <= '0;
            nega_q <= '0;
            cnt_q  <= '0;
            p_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        mul_q <= {b, 1'b0};
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                NEG: nega_q <= add_sum;
                CALC: begin
                    acc_q <= shift_d[ACC_W+WIDTH:WIDTH+1];
                    mul_q <= shift_d[WIDTH:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    // After the last shift, the product is acc[63:0] above mul[64:1].
                    if (cnt_q == LAST_ITER) p_q <= shift_d[2*WIDTH:1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vectors, reset abort, throughput, random stream.
// Latency: n/a.
// Backpressure: out_ready driven both held-low and randomly.
module tb_booth_mul_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  a_i;
    logic [63:0]  b_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
        int           hold;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: sign-extend to 128 bits and multiply; low 128 bits are the exact signed product.
    function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] ex;
        logic [127:0] ey;
        ex = {{64{x[63]}}, x};
        ey = {{64{y[63]}}, y};
        return ex * ey;
    endfunction

    function automatic logic [63:0] rnd();
        case ($urandom % 8)
            0:       return 64'h8000_0000_0000_0000;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'($urandom % 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboard: expected products in accept order, checked at each handshake.
    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           ncyc = 0;
    int           n_acc = 0;
    int           n_res = 0;
    int           prev_acc = 0;
    int           last_acc = 0;
    logic         prev_ov = 1'b0;
    logic         prev_or = 1'b0;
    logic [127:0] prev_p = '0;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (prev_ov && !prev_or) begin
                chk("mon_hold_valid", out_valid, 1'b1);
                chk("mon_hold_p", p, prev_p);
            end
            if (out_valid && !prev_ov && acc_q.size() > 0)
                chk("mon_latency", 128'(ncyc - acc_q[0]), 128'd34);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_output got=%h exp=none", p);
                end else begin
                    chk("mon_product", p, exp_q.pop_front());
                    void'(acc_q.pop_front());
                    n_res++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a_i, b_i));
                acc_q.push_back(ncyc);
                prev_acc = last_acc;
                last_acc = ncyc;
                n_acc++;
            end
        end
        prev_ov = out_valid && !rst;
        prev_or = out_ready;
        prev_p  = p;
    end

    // One full transaction with timing checks around accept, DONE and release.
    task automatic run_vec(input int idx);
        vec_t v;
        int   t;
        v = vecs[idx];
        @(posedge clk); #1;
        a_i = v.a; b_i = v.b; in_valid = 1'b1; out_ready = (v.hold == 0);
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("v%0d_accept_ready", idx), in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_i = {$urandom, $urandom};
        b_i = {$urandom, $urandom};
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 60);
        chk($sformatf("v%0d_latency", idx), 128'(t), 128'd34);
        chk($sformatf("v%0d_p", idx), p, v.p);
        chk($sformatf("v%0d_ready_in_done", idx), in_ready, 1'b0);
        if (v.hold > 0) begin
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_hold_valid", idx), out_valid, 1'b1);
                chk($sformatf("v%0d_hold_p", idx), p, v.p);
                chk($sformatf("v%0d_hold_ready", idx), in_ready, 1'b0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_rel_ready0", idx), in_ready, 1'b0);
            chk($sformatf("v%0d_rel_valid1", idx), out_valid, 1'b1);
            @(negedge clk);
            chk($sformatf("v%0d_rel_ready1", idx), in_ready, 1'b1);
            chk($sformatf("v%0d_rel_valid0", idx), out_valid, 1'b0);
        end else begin
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_ready_t36", idx), in_ready, 1'b1);
            chk($sformatf("v%0d_idle_p", idx), p, v.p);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int seen;
        int base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;

        vecs[0] = '{64'd3, 64'd5, 128'd15, 0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000, 0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                    128'hC000_0000_0000_0000_8000_0000_0000_0000, 0};
        vecs[4] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFF7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1, 10};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 0};
        vecs[6] = '{64'd6, 64'd7, 128'd42, 0};

        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_p", p, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Abort an operation during CALC iteration 12 (cycle T+14).
        @(posedge clk); #1;
        a_i = 64'd100; b_i = 64'hFFFF_FFFF_FFFF_FFFD; in_valid = 1'b1; out_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort_accept_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (13) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_p", p, 128'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_dropped", 128'(seen), 128'd0);
        run_vec(6);

        // Back-to-back with out_ready high: accepts every 35 cycles.
        @(posedge clk); #1;
        a_i = 64'd11; b_i = 64'hFFFF_FFFF_FFFF_FFF3; in_valid = 1'b1; out_ready = 1'b1;
        base = n_acc;
        t = 0;
        while (n_acc < base + 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("thru_accepts", 128'(n_acc - base), 128'd3);
        chk("thru_spacing", 128'(last_acc - prev_acc), 128'd35);
        repeat (45) @(negedge clk);

        // Random stream: in_valid held, operands change every cycle, random backpressure.
        base = n_res;
        t = 0;
        while (n_res < base + 1000 && t < 80000) begin
            @(posedge clk); #1;
            a_i = rnd();
            b_i = rnd();
            in_valid = 1'b1;
            out_ready = 1'($urandom % 2);
            t++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (50) @(negedge clk);
        chk("rand_results", 128'(n_res - base), 128'd1000);
        chk("rand_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
